// File: rtl/seg7_pkg.sv
// Shared seven-segment constants (active-low, bit0=a .. bit6=g) and reader state type.
// The display drivers use the same constants, so encode and decode cannot drift apart.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  localparam logic [3:0] DIGIT_INVALID = 4'hF;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of one active-low segment pattern to a BCD digit.
// Only exact matches are valid; anything else yields DIGIT_INVALID with valid_o low.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       valid_o,
  output logic [3:0] digit_o
);

  always_comb begin
    valid_o = 1'b1;
    digit_o = DIGIT_INVALID;
    case (seg_i)
      SEG_0:   digit_o = 4'd0;
      SEG_1:   digit_o = 4'd1;
      SEG_2:   digit_o = 4'd2;
      SEG_3:   digit_o = 4'd3;
      SEG_4:   digit_o = 4'd4;
      SEG_5:   digit_o = 4'd5;
      SEG_6:   digit_o = 4'd6;
      SEG_7:   digit_o = 4'd7;
      SEG_8:   digit_o = 4'd8;
      SEG_9:   digit_o = 4'd9;
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_digit_reader.sv
// Collects NUM_DIGITS decoded segment patterns into a BCD frame and presents it on valid/ready.
// Handshakes: a beat moves on a rising edge only when valid and ready are both high in that cycle.
module seg7_digit_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [6:0]              seg_in,
  input  logic                    seg_valid,
  output logic                    seg_ready,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    frame_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ERR_CNT_W-1:0]    err_cnt,
  output logic                    dbg_state
);

  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  localparam int ACC_W = 4 * NUM_DIGITS;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ACC_W-1:0]     acc_q, acc_d, acc_shift;
  logic                 err_flag_q, err_flag_d;
  logic [ACC_W-1:0]     bcd_q, bcd_d;
  logic                 frame_err_q, frame_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 dec_valid;
  logic [3:0]           dec_digit;
  logic                 xfer, last_digit;

  seg7_to_bcd u_dec (
    .seg_i   (seg_in),
    .valid_o (dec_valid),
    .digit_o (dec_digit)
  );

  assign xfer       = seg_valid && seg_ready;
  assign last_digit = (cnt_q == CNT_W'(NUM_DIGITS - 1));
  assign acc_shift  = (acc_q << 4) | ACC_W'(dec_digit);

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= COLLECT;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (xfer && last_digit) state_d = HOLD;
      HOLD:    if (out_ready)          state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    seg_ready = (state_q == COLLECT) && !clear;
    out_valid = (state_q == HOLD);
    dbg_state = state_q;
  end

  // Partial-frame state clears on clear in COLLECT and on release of a presented frame.
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    err_flag_d  = err_flag_q;
    bcd_d       = bcd_q;
    frame_err_d = frame_err_q;
    err_cnt_d   = err_cnt_q;
    if (state_q == COLLECT) begin
      if (clear) begin
        cnt_d      = '0;
        acc_d      = '0;
        err_flag_d = 1'b0;
      end else if (xfer) begin
        cnt_d      = cnt_q + CNT_W'(1);
        acc_d      = acc_shift;
        err_flag_d = err_flag_q | !dec_valid;
        if (last_digit) begin
          bcd_d       = acc_shift;
          frame_err_d = err_flag_q | !dec_valid;
        end
      end
    end else if (out_ready) begin
      cnt_d      = '0;
      acc_d      = '0;
      err_flag_d = 1'b0;
    end
    if (xfer && !dec_valid && (err_cnt_q != {ERR_CNT_W{1'b1}}))
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      err_flag_q  <= 1'b0;
      bcd_q       <= '0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      err_flag_q  <= err_flag_d;
      bcd_q       <= bcd_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bcd_out   = bcd_q;
  assign frame_err = frame_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_seg7_digit_reader.sv
// Directed bench for seg7_digit_reader: hand-computed frames plus a scoreboard for randomised gaps.
// A second instance with a 2-bit error counter shares the inputs to exercise saturation.
module tb_seg7_digit_reader;

  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic        clk = 1'b0;
  logic        resetn;
  logic [6:0]  seg_in;
  logic        seg_valid;
  logic        seg_ready;
  logic        clear;
  logic [15:0] bcd_out;
  logic        frame_err;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  err_cnt;
  logic        dbg_state;

  logic        seg_ready2, frame_err2, out_valid2, dbg_state2;
  logic [15:0] bcd_out2;
  logic [1:0]  err_cnt2;

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard: {frame_err, bcd} per completed frame, plus reference accumulator.
  logic [16:0] exp_q[$];
  logic [16:0] cur_exp;
  logic [15:0] mdl_acc;
  int          mdl_cnt;
  logic        mdl_err;
  int          mdl_ec8, mdl_ec2;

  always #5 clk = ~clk;

  seg7_digit_reader #(.NUM_DIGITS(4), .ERR_CNT_W(8)) dut (
    .clk(clk), .resetn(resetn), .seg_in(seg_in), .seg_valid(seg_valid),
    .seg_ready(seg_ready), .clear(clear), .bcd_out(bcd_out), .frame_err(frame_err),
    .out_valid(out_valid), .out_ready(out_ready), .err_cnt(err_cnt), .dbg_state(dbg_state)
  );

  seg7_digit_reader #(.NUM_DIGITS(4), .ERR_CNT_W(2)) dut_w2 (
    .clk(clk), .resetn(resetn), .seg_in(seg_in), .seg_valid(seg_valid),
    .seg_ready(seg_ready2), .clear(clear), .bcd_out(bcd_out2), .frame_err(frame_err2),
    .out_valid(out_valid2), .out_ready(out_ready), .err_cnt(err_cnt2), .dbg_state(dbg_state2)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500us");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [3:0] ref_digit(input logic [6:0] p);
    logic [3:0] d;
    d = 4'hF;
    for (int i = 0; i < 10; i++) if (SEG_TAB[i] == p) d = 4'(i);
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mdl_acc = '0;
    mdl_cnt = 0;
    mdl_err = 1'b0;
  endtask

  // Offers one pattern, waits (bounded) for seg_ready, returns #1 after the accepting edge.
  task automatic send(input logic [6:0] p);
    int n;
    logic [3:0] d;
    n = 0;
    seg_in    = p;
    seg_valid = 1'b1;
    while (!seg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready_timeout", seg_ready, 1'b1);
    @(posedge clk);
    #1;
    seg_valid = 1'b0;
    d = ref_digit(p);
    mdl_acc = {mdl_acc[11:0], d};
    mdl_cnt++;
    if (d == 4'hF) begin
      mdl_err = 1'b1;
      if (mdl_ec8 < 255) mdl_ec8++;
      if (mdl_ec2 < 3)   mdl_ec2++;
    end
    if (mdl_cnt == 4) begin
      exp_q.push_back({mdl_err, mdl_acc});
      model_reset();
    end
  endtask

  task automatic idle(input int n);
    seg_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits for a frame, checks it against the scoreboard, optionally releases it.
  task automatic check_frame(input int hold, input bit rel);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("frame_valid_timeout", out_valid, 1'b1);
    if (exp_q.size() == 0) begin
      chk("sb_underflow", 32'(exp_q.size()), 32'd1);
      cur_exp = '0;
    end else begin
      cur_exp = exp_q.pop_front();
    end
    chk("sb_bcd", bcd_out, cur_exp[15:0]);
    chk("sb_frame_err", frame_err, cur_exp[16]);
    chk("sb_err_cnt", err_cnt, 32'(mdl_ec8));
    chk("sb_err_cnt_w2", err_cnt2, 32'(mdl_ec2));
    repeat (hold) @(negedge clk);
    chk("hold_bcd_stable", bcd_out, cur_exp[15:0]);
    chk("hold_seg_ready", seg_ready, 1'b0);
    if (rel) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("rel_out_valid", out_valid, 1'b0);
      chk("rel_bcd_kept", bcd_out, cur_exp[15:0]);
    end
  endtask

  initial begin
    resetn    = 1'b0;
    seg_in    = 7'h7F;
    seg_valid = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b0;
    mdl_ec8   = 0;
    mdl_ec2   = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;

    // Reset state
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_bcd", bcd_out, 16'h0000);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_err_cnt", err_cnt, 8'd0);
    chk("rst_seg_ready", seg_ready, 1'b1);
    chk("rst_state", dbg_state, 1'b0);

    // 1: digits 1,2,3,4, one-cycle latency to out_valid
    send(SEG_TAB[1]); send(SEG_TAB[2]); send(SEG_TAB[3]);
    chk("t1_not_yet_valid", out_valid, 1'b0);
    send(SEG_TAB[4]);
    chk("t1_latency", out_valid, 1'b1);
    chk("t1_bcd", bcd_out, 16'h1234);
    chk("t1_frame_err", frame_err, 1'b0);
    chk("t1_seg_ready", seg_ready, 1'b0);
    chk("t1_err_cnt", err_cnt, 8'd0);
    chk("t1_state", dbg_state, 1'b1);
    check_frame(3, 1'b0);

    // 2: release with seg_valid held high; the 9 is only taken after release
    seg_in    = SEG_TAB[9];
    seg_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("t2_out_valid", out_valid, 1'b0);
    chk("t2_seg_ready", seg_ready, 1'b1);
    chk("t2_bcd_kept", bcd_out, 16'h1234);
    send(SEG_TAB[9]); send(SEG_TAB[8]); send(SEG_TAB[7]); send(SEG_TAB[6]);
    chk("t2_bcd", bcd_out, 16'h9876);
    check_frame(0, 1'b1);

    // 3: invalid all-off pattern, then a clean frame
    send(SEG_TAB[0]); send(7'b1111111); send(SEG_TAB[5]); send(SEG_TAB[7]);
    chk("t3_bcd", bcd_out, 16'h0F57);
    chk("t3_frame_err", frame_err, 1'b1);
    chk("t3_err_cnt", err_cnt, 8'd1);
    check_frame(2, 1'b1);
    send(SEG_TAB[1]); send(SEG_TAB[2]); send(SEG_TAB[3]); send(SEG_TAB[4]);
    chk("t3_clean_frame_err", frame_err, 1'b0);
    chk("t3_clean_err_cnt", err_cnt, 8'd1);
    check_frame(1, 1'b1);

    // 4: clear drops the partial frame and blocks the offered pattern
    send(SEG_TAB[2]); send(SEG_TAB[3]);
    seg_in    = SEG_TAB[9];
    seg_valid = 1'b1;
    clear     = 1'b1;
    #1;
    chk("t4_clear_blocks_ready", seg_ready, 1'b0);
    @(posedge clk);
    #1;
    clear     = 1'b0;
    seg_valid = 1'b0;
    model_reset();
    send(SEG_TAB[4]); send(SEG_TAB[5]); send(SEG_TAB[6]); send(SEG_TAB[7]);
    chk("t4_bcd", bcd_out, 16'h4567);
    check_frame(0, 1'b1);

    // 5: reset mid-frame discards everything including err_cnt
    send(SEG_TAB[2]); send(SEG_TAB[3]);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    model_reset();
    exp_q.delete();
    mdl_ec8 = 0;
    mdl_ec2 = 0;
    chk("t5_rst_bcd", bcd_out, 16'h0000);
    chk("t5_rst_err_cnt", err_cnt, 8'd0);
    chk("t5_rst_out_valid", out_valid, 1'b0);
    send(SEG_TAB[8]); send(SEG_TAB[8]); send(SEG_TAB[8]); send(SEG_TAB[8]);
    chk("t5_bcd", bcd_out, 16'h8888);
    chk("t5_err_cnt", err_cnt, 8'd0);
    check_frame(0, 1'b1);

    // 6a: five invalid patterns saturate the 2-bit counter at 3
    send(7'h7F); send(7'h55); send(7'h2A); send(7'h7E);
    chk("t6_bcd_all_invalid", bcd_out, 16'hFFFF);
    check_frame(0, 1'b1);
    send(7'h01);
    chk("t6_err_cnt_w2_sat", err_cnt2, 2'd3);
    chk("t6_err_cnt_w8", err_cnt, 8'd5);

    // 6b: random patterns with random valid gaps and out_ready delays
    for (int i = 0; i < 40; i++) begin
      int idx;
      idle($urandom_range(0, 3));
      idx = $urandom_range(0, 11);
      if (idx < 10) send(SEG_TAB[idx]);
      else          send(7'($urandom_range(0, 127)));
      if (exp_q.size() > 0) check_frame($urandom_range(0, 4), 1'b1);
    end
    while (mdl_cnt != 0) begin
      send(SEG_TAB[$urandom_range(0, 9)]);
    end
    if (exp_q.size() > 0) check_frame(0, 1'b1);
    chk("t6_sb_drained", 32'(exp_q.size()), 32'd0);
    chk("t6_final_out_valid", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
